// File: rtl/cpc_audio_pkg.sv
// cpc_audio_pkg: shared definitions for the CPC PSG audio mixer.
//   - FSM state encoding (IDLE / ACC / DONE)
//   - config byte field offsets and the unpacked per-channel config struct
//   - legacy default mix (A-left, B-centre-half, C-right)
//   - clog2 helper usable in parameter expressions
package cpc_audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Config byte layout: [3:0] gain, [4] left, [5] right, [6] reserved, [7] mute
  localparam int unsigned CFG_GAIN_LSB = 0;
  localparam int unsigned CFG_GAIN_W   = 4;
  localparam int unsigned CFG_L        = 4;
  localparam int unsigned CFG_R        = 5;
  localparam int unsigned CFG_RSVD     = 6;
  localparam int unsigned CFG_MUTE     = 7;

  // Legacy three-channel mix, channel 0 in the LSBs: 0x18 = A left gain 8,
  // 0x34 = B both gain 4, 0x28 = C right gain 8.
  localparam logic [23:0] LEGACY_CFG3 = 24'h28_34_18;
  localparam logic [47:0] LEGACY_CFG  = {2{LEGACY_CFG3}};

  // Upper bound on channels covered by the generated default config
  localparam int unsigned MAX_NCH = 64;

  // Reserved bit is dropped; nothing downstream ever looks at it.
  typedef struct packed {
    logic       mute;
    logic       r_en;
    logic       l_en;
    logic [3:0] gain;
  } ch_cfg_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Legacy pattern repeated every three channels (one PSG per group of three)
  function automatic logic [8*MAX_NCH-1:0] legacy_cfg();
    logic [8*MAX_NCH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_NCH; i++) begin
      r[8*i +: 8] = LEGACY_CFG3[8*(i%3) +: 8];
    end
    return r;
  endfunction

  function automatic ch_cfg_t cfg_unpack(input logic [7:0] b);
    ch_cfg_t c;
    logic    unused_rsvd;
    unused_rsvd = b[CFG_RSVD];
    c.mute = b[CFG_MUTE];
    c.r_en = b[CFG_R];
    c.l_en = b[CFG_L];
    c.gain = b[CFG_GAIN_LSB +: CFG_GAIN_W];
    return c;
  endfunction

endpackage

// File: rtl/cpc_audio_mixer_mac.sv
// cpc_audio_mac: single-channel multiply, gated dual accumulate and the final
// shift/saturate output stage of the mixer.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_clr         clear both accumulators (start of frame)
//   i_en          accumulate the current channel this clk
//   i_latch       register saturated (acc >> 4) into o_l / o_r
//   i_smp         current channel sample
//   i_gain        current channel gain (x/16)
//   i_l_en/i_r_en current channel routing
//   i_mute        current channel mute
//   o_l, o_r      registered left/right mix, held between frames
module cpc_audio_mac #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned ACC_W = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_latch,
  input  logic [IN_W-1:0]  i_smp,
  input  logic [3:0]       i_gain,
  input  logic             i_l_en,
  input  logic             i_r_en,
  input  logic             i_mute,
  output logic [OUT_W-1:0] o_l,
  output logic [OUT_W-1:0] o_r
);

  localparam int unsigned PW = IN_W + 4;
  localparam int unsigned CW = (ACC_W > OUT_W) ? ACC_W : OUT_W;

  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] r_acc_l;
  logic [ACC_W-1:0] r_acc_r;
  logic [CW-1:0]    w_sh_l;
  logic [CW-1:0]    w_sh_r;

  assign w_prod = PW'(i_smp) * PW'(i_gain);
  assign w_sh_l = CW'(r_acc_l >> 4);
  assign w_sh_r = CW'(r_acc_r >> 4);

  function automatic logic [OUT_W-1:0] sat(input logic [CW-1:0] v);
    if (v > CW'({OUT_W{1'b1}})) return '1;
    return v[OUT_W-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (i_clr) begin
      r_acc_l <= '0;
      r_acc_r <= '0;
    end else if (i_en && !i_mute) begin
      if (i_l_en) r_acc_l <= r_acc_l + ACC_W'(w_prod);
      if (i_r_en) r_acc_r <= r_acc_r + ACC_W'(w_prod);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_l <= '0;
      o_r <= '0;
    end else if (i_latch) begin
      o_l <= sat(w_sh_l);
      o_r <= sat(w_sh_r);
    end
  end

endmodule

// File: rtl/cpc_audio_mixer.sv
// cpc_audio_mixer: N-channel stereo PSG mixer with per-channel gain, routing
// and mute. One channel is accumulated per clk after each ce; results are
// saturated and presented with a one-clk valid strobe.
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   ce        sample strobe (one clk wide)
//   ch_in     NCH samples of IN_W bits, channel 0 in the LSBs
//   cfg_wr    config write strobe
//   cfg_addr  channel index to write (out-of-range writes ignored)
//   cfg_din   config byte: [3:0] gain, [4] L, [5] R, [6] reserved, [7] mute
//   audio_l   left mix
//   audio_r   right mix
//   valid     one-clk pulse when audio_l/audio_r update
//   overrun   sticky: ce arrived mid-frame; cleared by an accepted cfg write
module cpc_audio_mixer
  import cpc_audio_pkg::*;
#(
  parameter int unsigned      NCH     = 6,
  parameter int unsigned      IN_W    = 8,
  parameter int unsigned      OUT_W   = 8,
  parameter logic [8*NCH-1:0] DEF_CFG = (8*NCH)'(legacy_cfg()),
  localparam int unsigned     AW      = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ce,
  input  logic [NCH*IN_W-1:0] ch_in,
  input  logic                cfg_wr,
  input  logic [AW-1:0]       cfg_addr,
  input  logic [7:0]          cfg_din,
  output logic [OUT_W-1:0]    audio_l,
  output logic [OUT_W-1:0]    audio_r,
  output logic                valid,
  output logic                overrun
);

  localparam int unsigned ACC_W = IN_W + 4 + clog2(NCH);

  state_t          r_state;
  state_t          w_state_nxt;
  ch_cfg_t         r_cfg      [NCH];
  ch_cfg_t         r_snap_cfg [NCH];
  logic [IN_W-1:0] r_snap_smp [NCH];
  logic [AW-1:0]   r_idx;
  logic            r_valid;
  logic            r_overrun;

  logic            w_start;
  logic            w_acc_en;
  logic            w_latch;
  logic            w_last;
  logic            w_wr_ok;
  ch_cfg_t         w_cur_cfg;
  logic [IN_W-1:0] w_cur_smp;

  assign w_wr_ok   = cfg_wr && (32'(cfg_addr) < NCH);
  assign w_last    = (32'(r_idx) == NCH - 1);
  assign w_cur_cfg = r_snap_cfg[r_idx];
  assign w_cur_smp = r_snap_smp[r_idx];

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_acc_en    = 1'b0;
    w_latch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ce) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        w_acc_en = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_latch     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_latch;
      if (w_start) r_idx <= '0;
      else if (w_acc_en && !w_last) r_idx <= r_idx + AW'(1);
    end
  end

  // Snapshot reads r_cfg before any same-clk write lands, so a write that
  // coincides with ce only affects the following frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_cfg[i]      <= cfg_unpack(DEF_CFG[8*i +: 8]);
        r_snap_cfg[i] <= '0;
        r_snap_smp[i] <= '0;
      end
    end else begin
      if (w_start) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          r_snap_cfg[i] <= r_cfg[i];
          r_snap_smp[i] <= ch_in[IN_W*i +: IN_W];
        end
      end
      if (w_wr_ok) r_cfg[cfg_addr] <= cfg_unpack(cfg_din);
    end
  end

  // A dropped sample in the same clk as a clearing write still flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (ce && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end else if (w_wr_ok) begin
      r_overrun <= 1'b0;
    end
  end

  cpc_audio_mac #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (reset),
    .i_clr   (w_start),
    .i_en    (w_acc_en),
    .i_latch (w_latch),
    .i_smp   (w_cur_smp),
    .i_gain  (w_cur_cfg.gain),
    .i_l_en  (w_cur_cfg.l_en),
    .i_r_en  (w_cur_cfg.r_en),
    .i_mute  (w_cur_cfg.mute),
    .o_l     (audio_l),
    .o_r     (audio_r)
  );

  assign valid   = r_valid;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_cpc_audio_mixer.sv
module tb_cpc_audio_mixer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NCH=3 instance
  logic        ce3 = 1'b0, wr3 = 1'b0;
  logic [1:0]  addr3 = '0;
  logic [7:0]  din3 = '0;
  logic [23:0] ch3 = '0;
  logic [7:0]  l3, r3;
  logic        v3, ov3;

  // NCH=6 instance
  logic        ce6 = 1'b0, wr6 = 1'b0;
  logic [2:0]  addr6 = '0;
  logic [7:0]  din6 = '0;
  logic [47:0] ch6 = '0;
  logic [7:0]  l6, r6;
  logic        v6, ov6;

  cpc_audio_mixer #(.NCH(3), .IN_W(8), .OUT_W(8), .DEF_CFG(24'h28_34_18)) u3 (
    .clk(clk), .reset(rst), .ce(ce3), .ch_in(ch3), .cfg_wr(wr3), .cfg_addr(addr3),
    .cfg_din(din3), .audio_l(l3), .audio_r(r3), .valid(v3), .overrun(ov3)
  );

  cpc_audio_mixer #(.NCH(6), .IN_W(8), .OUT_W(8), .DEF_CFG(48'h28_34_18_28_34_18)) u6 (
    .clk(clk), .reset(rst), .ce(ce6), .ch_in(ch6), .cfg_wr(wr6), .cfg_addr(addr6),
    .cfg_din(din6), .audio_l(l6), .audio_r(r6), .valid(v6), .overrun(ov6)
  );

  typedef struct {
    logic [7:0]  l;
    logic [7:0]  r;
    int unsigned due;
  } exp_t;

  exp_t q3[$];
  exp_t q6[$];

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop expected frame on every valid pulse
  always @(negedge clk) begin : mon3
    exp_t e;
    if (!rst && v3) begin
      if (q3.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u3 spurious valid: got l=%0d r=%0d expected no pulse", l3, r3);
      end else begin
        e = q3.pop_front();
        check("u3 audio_l", l3, e.l);
        check("u3 audio_r", r3, e.r);
        check("u3 latency", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon6
    exp_t e;
    if (!rst && v6) begin
      if (q6.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL u6 spurious valid: got l=%0d r=%0d expected no pulse", l6, r6);
      end else begin
        e = q6.pop_front();
        check("u6 audio_l", l6, e.l);
        check("u6 audio_r", r6, e.r);
        check("u6 latency", cyc, e.due);
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // ce sampled at edge cyc+1; valid visible NCH+1 edges later
  task automatic frame3(input logic [7:0] a, b, c, input logic [7:0] el, er);
    ch3 = {c, b, a};
    ce3 = 1'b1;
    q3.push_back('{l: el, r: er, due: cyc + 5});
    @(negedge clk);
    ce3 = 1'b0;
  endtask

  task automatic frame6(input logic [47:0] smp, input logic [7:0] el, er);
    ch6 = smp;
    ce6 = 1'b1;
    q6.push_back('{l: el, r: er, due: cyc + 8});
    @(negedge clk);
    ce6 = 1'b0;
  endtask

  task automatic cfg3(input logic [1:0] a, input logic [7:0] d);
    wr3 = 1'b1; addr3 = a; din3 = d;
    @(negedge clk);
    wr3 = 1'b0;
  endtask

  task automatic cfg6(input logic [2:0] a, input logic [7:0] d);
    wr6 = 1'b1; addr6 = a; din6 = d;
    @(negedge clk);
    wr6 = 1'b0;
  endtask

  task automatic cfg6_all(input logic [7:0] d);
    for (int i = 0; i < 6; i++) cfg6(3'(i), d);
  endtask

  task automatic drain(input bit six);
    int unsigned n;
    n = 0;
    while (((six ? q6.size() : q3.size()) != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(six ? "u6 drain pending" : "u3 drain pending", six ? q6.size() : q3.size(), 0);
    tick(2);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    rst = 1'b0;
    tick(1);
    check("u3 reset audio_l", l3, 0);
    check("u3 reset audio_r", r3, 0);
    check("u3 reset valid", v3, 0);
    check("u3 reset overrun", ov3, 0);
    check("u6 reset audio_l", l6, 0);
    check("u6 reset audio_r", r6, 0);
    check("u6 reset valid", v6, 0);
    check("u6 reset overrun", ov6, 0);

    // NCH=3, default legacy mix
    frame3(8'd255, 8'd0, 8'd0, 8'd127, 8'd0);      drain(0);
    frame3(8'd0, 8'd255, 8'd0, 8'd63, 8'd63);      drain(0);
    frame3(8'd255, 8'd255, 8'd255, 8'd191, 8'd191); drain(0);
    frame3(8'd100, 8'd50, 8'd200, 8'd62, 8'd112);  drain(0);

    // ce exactly NCH+2 clks apart: both accepted, no overrun
    frame3(8'd255, 8'd0, 8'd0, 8'd127, 8'd0);
    tick(4);
    frame3(8'd0, 8'd0, 8'd255, 8'd0, 8'd127);
    drain(0);
    check("u3 overrun spaced ce", ov3, 0);

    // ce 2 clks after the first: dropped, first frame values, ch_in change ignored
    frame3(8'd0, 8'd255, 8'd0, 8'd63, 8'd63);
    tick(1);
    ch3 = {8'd255, 8'd255, 8'd255};
    ce3 = 1'b1;
    @(negedge clk);
    ce3 = 1'b0;
    check("u3 overrun set", ov3, 1);
    drain(0);
    check("u3 overrun sticky", ov3, 1);
    cfg3(2'd3, 8'h00);
    check("u3 overrun after ignored write", ov3, 1);
    cfg3(2'd2, 8'h28);
    check("u3 overrun cleared", ov3, 0);
    frame3(8'd255, 8'd255, 8'd255, 8'd191, 8'd191); drain(0);

    // mute write in the same clk as ce: old cfg for this frame
    ch3 = {8'd0, 8'd0, 8'd255};
    wr3 = 1'b1; addr3 = 2'd0; din3 = 8'h80;
    ce3 = 1'b1;
    q3.push_back('{l: 8'd127, r: 8'd0, due: cyc + 5});
    @(negedge clk);
    wr3 = 1'b0;
    ce3 = 1'b0;
    drain(0);
    frame3(8'd255, 8'd0, 8'd0, 8'd0, 8'd0);        drain(0);
    frame3(8'd255, 8'd255, 8'd255, 8'd63, 8'd191); drain(0);

    // reset while accumulating at idx=1, with overrun set by a held ce
    ch3 = {8'd0, 8'd0, 8'd255};
    ce3 = 1'b1;
    tick(2);
    check("u3 overrun before reset", ov3, 1);
    ce3 = 1'b0;
    rst = 1'b1;
    tick(2);
    check("u3 mid-frame reset audio_l", l3, 0);
    check("u3 mid-frame reset audio_r", r3, 0);
    check("u3 mid-frame reset valid", v3, 0);
    check("u3 mid-frame reset overrun", ov3, 0);
    rst = 1'b0;
    tick(8);
    frame3(8'd255, 8'd0, 8'd0, 8'd127, 8'd0);      drain(0);

    // NCH=6, default config
    frame6({8'd16, 8'd0, 8'd0, 8'd200, 8'd50, 8'd100}, 8'd62, 8'd120); drain(1);

    // all channels gain 15 both sides, full scale: 22950>>4 saturates
    cfg6_all(8'h3F);
    frame6({6{8'd255}}, 8'd255, 8'd255); drain(1);

    // gain 0 everywhere: zero output, valid still pulses
    cfg6_all(8'h30);
    frame6({6{8'd255}}, 8'd0, 8'd0); drain(1);

    // acc = 4096 -> 256 must saturate, not wrap
    cfg6(3'd0, 8'h3F);
    cfg6(3'd1, 8'h31);
    cfg6(3'd2, 8'h31);
    frame6({8'd255, 8'd255, 8'd255, 8'd16, 8'd255, 8'd255}, 8'd255, 8'd255); drain(1);

    // mute channel 0: 255 + 16 = 271 -> 16
    cfg6(3'd0, 8'hBF);
    frame6({8'd255, 8'd255, 8'd255, 8'd16, 8'd255, 8'd255}, 8'd16, 8'd16); drain(1);
    check("u6 overrun clear", ov6, 0);

    check("u3 leftover expected", q3.size(), 0);
    check("u6 leftover expected", q6.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
